// File: rtl/trng_pkg.sv
// -----------------------------------------------------------------------------
// trng_pkg
// Shared types and constants for the TRNG post-processing blocks.
//   coll_state_e    : word collector FSM state encoding (also exported on the
//                     collector debug port)
//   TRNG_WORD_W     : default width of collected entropy words
//   TRNG_RCT_*/APT_*: health-test thresholds shared with the health block
// -----------------------------------------------------------------------------
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STARTUP = 2'd1,
    ST_RUN     = 2'd2,
    ST_FAULT   = 2'd3
  } coll_state_e;

  localparam int TRNG_WORD_W     = 32;

  // Repetition-count and adaptive-proportion test limits.
  localparam int TRNG_RCT_CUTOFF = 40;
  localparam int TRNG_APT_WINDOW = 1024;
  localparam int TRNG_APT_CUTOFF = 589;

endpackage

// File: rtl/trng_sync_fifo.sv
// -----------------------------------------------------------------------------
// trng_sync_fifo
// Show-ahead synchronous FIFO for collected entropy words.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : synchronous clear (empties the FIFO, wins over push/pop)
//   push_i       : write wdata_i; accepted when not full or when a pop
//                  happens in the same cycle
//   pop_i        : remove the head word (ignored when empty)
//   wdata_i      : word to write
//   rdata_o      : head word (0 when empty)
//   full_o       : level == DEPTH
//   empty_o      : level == 0
//   level_o      : occupied entries
// -----------------------------------------------------------------------------
module trng_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO can still take a word when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/trng_word_collector.sv
// -----------------------------------------------------------------------------
// trng_word_collector
// Packs debiased TRNG bits into WORD_W-bit words after a startup discard run,
// queues them in a small FIFO and handles health-failure / flush recovery.
//   clk, rst_n    : clock, asynchronous active-low reset
//   bit_in        : debiased bit, qualified by bit_strobe
//   bit_strobe    : one-cycle bit-valid pulse
//   health_fail   : combined health-test failure (sticky upstream)
//   enable        : collect while high
//   flush         : one-cycle software clear request
//   health_clear  : one-cycle clear pulse to the health block
//   m_data/m_valid/m_ready : word output stream
//   startup_done  : high while in RUN
//   fault         : high while in FAULT
//   overflow      : sticky, a completed word was dropped (FIFO full)
//   fifo_level    : occupied FIFO entries
//   dbg_state     : current FSM state (coll_state_e encoding)
//
// Output handshake: m_data is the FIFO head and holds steady while
// m_valid & !m_ready; a word transfers on every cycle with m_valid & m_ready.
// m_valid does not depend on m_ready.
// -----------------------------------------------------------------------------
module trng_word_collector
  import trng_pkg::*;
#(
  parameter int WORD_W       = TRNG_WORD_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARTUP_BITS = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              bit_in,
  input  logic                              bit_strobe,
  input  logic                              health_fail,
  input  logic                              enable,
  input  logic                              flush,
  output logic                              health_clear,
  output logic [WORD_W-1:0]                 m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              startup_done,
  output logic                              fault,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic [1:0]                        dbg_state
);

  localparam int SCW = $clog2(STARTUP_BITS+1);
  localparam int BCW = $clog2(WORD_W);
  localparam logic [SCW-1:0] START_LAST = SCW'(STARTUP_BITS-1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(WORD_W-1);

  coll_state_e       state_q, state_d;
  logic [SCW-1:0]    start_cnt_q, start_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              overflow_q, overflow_d;
  logic              hclr_q, hclr_d;

  logic              fifo_push, fifo_pop, fifo_clr;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] word_next;

  // Word as it looks after shifting in the current bit; this is what gets
  // pushed on the strobe that completes a word.
  assign word_next = {sreg_q[WORD_W-2:0], bit_in};

  assign m_valid   = ~fifo_empty & (state_q != ST_FAULT);
  assign fifo_pop  = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_cnt_q <= '0;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      overflow_q  <= 1'b0;
      hclr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      overflow_q  <= overflow_d;
      hclr_q      <= hclr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sreg_d      = sreg_q;
    overflow_d  = overflow_q;
    hclr_d      = 1'b0;
    fifo_clr    = 1'b0;
    fifo_push   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          hclr_d      = 1'b1;
          fifo_clr    = 1'b1;
          overflow_d  = 1'b0;
          start_cnt_d = '0;
          bit_cnt_d   = '0;
          sreg_d      = '0;
        end else if (enable) begin
          state_d     = ST_STARTUP;
          start_cnt_d = '0;
        end
      end

      ST_STARTUP, ST_RUN: begin
        if (health_fail) begin
          // Purge all entropy; a word completing this cycle is lost too.
          state_d     = ST_FAULT;
          fifo_clr    = 1'b1;
          start_cnt_d = '0;
          bit_cnt_d   = '0;
          sreg_d      = '0;
        end else if (flush) begin
          state_d     = ST_IDLE;
          hclr_d      = 1'b1;
          fifo_clr    = 1'b1;
          overflow_d  = 1'b0;
          start_cnt_d = '0;
          bit_cnt_d   = '0;
          sreg_d      = '0;
        end else if (!enable) begin
          // Partial word is dropped; queued words stay drainable.
          state_d     = ST_IDLE;
          start_cnt_d = '0;
          bit_cnt_d   = '0;
          sreg_d      = '0;
        end else if (bit_strobe) begin
          if (state_q == ST_STARTUP) begin
            if (start_cnt_q == START_LAST) begin
              state_d     = ST_RUN;
              start_cnt_d = '0;
            end else begin
              start_cnt_d = start_cnt_q + 1'b1;
            end
          end else begin
            sreg_d = word_next;
            if (bit_cnt_q == BIT_LAST) begin
              fifo_push = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end

      ST_FAULT: begin
        if (flush) begin
          state_d     = ST_IDLE;
          hclr_d      = 1'b1;
          fifo_clr    = 1'b1;
          overflow_d  = 1'b0;
          start_cnt_d = '0;
          bit_cnt_d   = '0;
          sreg_d      = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Mirrors the FIFO's accept rule so the drop is flagged exactly when the
    // FIFO refuses the word.
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  trng_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (word_next),
    .rdata_o (m_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign health_clear = hclr_q;
  assign startup_done = (state_q == ST_RUN);
  assign fault        = (state_q == ST_FAULT);
  assign overflow     = overflow_q;
  assign dbg_state    = state_q;

endmodule
